// File: rtl/avalon_to_wb_bridge_if.sv
// Bus bundle for the Avalon-MM slave / Wishbone master bridge.
// The slave modport is the bridge view; the master modport is the environment view.
interface avalon_to_wb_bridge_if #(
    parameter int DW  = 32,
    parameter int AW  = 30,
    parameter int BCW = 8
);
    logic [AW-1:0]   s_av_address_i;
    logic [DW/8-1:0] s_av_byteenable_i;
    logic            s_av_read_i;
    logic            s_av_write_i;
    logic [DW-1:0]   s_av_writedata_i;
    logic [BCW-1:0]  s_av_burstcount_i;
    logic [DW-1:0]   s_av_readdata_o;
    logic            s_av_readdatavalid_o;
    logic            s_av_waitrequest_o;
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW-1:0]   wb_dat_i;
    logic [DW/8-1:0] wb_sel_o;
    logic            wb_we_o;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic [2:0]      wb_cti_o;
    logic [1:0]      wb_bte_o;
    logic            wb_ack_i;
    logic            wb_err_i;
    logic            err_o;

    modport slave (
        input  s_av_address_i, s_av_byteenable_i, s_av_read_i,
        input  s_av_write_i, s_av_writedata_i, s_av_burstcount_i,
        input  wb_dat_i, wb_ack_i, wb_err_i,
        output s_av_readdata_o, s_av_readdatavalid_o, s_av_waitrequest_o,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o,
        output wb_stb_o, wb_cti_o, wb_bte_o, err_o
    );

    modport master (
        output s_av_address_i, s_av_byteenable_i, s_av_read_i,
        output s_av_write_i, s_av_writedata_i, s_av_burstcount_i,
        output wb_dat_i, wb_ack_i, wb_err_i,
        input  s_av_readdata_o, s_av_readdatavalid_o, s_av_waitrequest_o,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o,
        input  wb_stb_o, wb_cti_o, wb_bte_o, err_o
    );
endinterface

// File: rtl/avalon_to_wb_bridge.sv
// Avalon-MM slave to Wishbone B4 master: one Avalon burst maps to one
// Wishbone cycle with cyc held and one stb/ack handshake per beat.
module avalon_to_wb_bridge #(
    parameter int DW            = 32,
    parameter int AW            = 30,
    parameter int BCW           = 8,
    parameter int BURST_SUPPORT = 1
) (
    input logic wb_clk_i,
    input logic wb_rst_i,
    avalon_to_wb_bridge_if.slave bus
);
    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        WR_GAP
    } state_e;

    state_e          state_q, state_d;
    logic            ready_q, ready_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [BCW:0]    rem_q, rem_d;
    logic [DW-1:0]   wdat_q, wdat_d;
    logic [SW-1:0]   wsel_q, wsel_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            err_q, err_d;
    logic            beat;
    logic            last;
    logic [BCW:0]    cnt;

    assign beat = bus.wb_ack_i | bus.wb_err_i;
    assign last = (rem_q == (BCW+1)'(1));
    // A zero burstcount is a single beat
    assign cnt = (bus.s_av_burstcount_i == '0) ? (BCW+1)'(1)
                                               : {1'b0, bus.s_av_burstcount_i};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            addr_q   <= '0;
            rem_q    <= '0;
            wdat_q   <= '0;
            wsel_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            wdat_q   <= wdat_d;
            wsel_q   <= wsel_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ready_d  = 1'b1;
        addr_d   = addr_q;
        rem_d    = rem_q;
        wdat_d   = wdat_q;
        wsel_d   = wsel_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (ready_q && bus.s_av_read_i) begin
                    addr_d  = bus.s_av_address_i;
                    rem_d   = cnt;
                    state_d = RD;
                end else if (ready_q && bus.s_av_write_i) begin
                    addr_d  = bus.s_av_address_i;
                    rem_d   = cnt;
                    wdat_d  = bus.s_av_writedata_i;
                    wsel_d  = bus.s_av_byteenable_i;
                    state_d = WR;
                end
            end
            RD: begin
                if (beat) begin
                    rvalid_d = 1'b1;
                    rdata_d  = bus.wb_err_i ? {DW{1'b1}} : bus.wb_dat_i;
                    err_d    = err_q | bus.wb_err_i;
                    addr_d   = addr_q + AW'(1);
                    rem_d    = rem_q - (BCW+1)'(1);
                    if (last) state_d = IDLE;
                end
            end
            WR: begin
                if (beat) begin
                    err_d = err_q | bus.wb_err_i;
                    if (last) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        rem_d   = rem_q - (BCW+1)'(1);
                        state_d = WR_GAP;
                    end
                end
            end
            WR_GAP: begin
                // Reads are ignored until the write burst finishes
                if (bus.s_av_write_i) begin
                    wdat_d  = bus.s_av_writedata_i;
                    wsel_d  = bus.s_av_byteenable_i;
                    state_d = WR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.wb_cyc_o = (state_q != IDLE);
    assign bus.wb_stb_o = (state_q == RD) || (state_q == WR);
    assign bus.wb_we_o  = (state_q == WR) || (state_q == WR_GAP);
    assign bus.wb_adr_o = addr_q;
    assign bus.wb_dat_o = wdat_q;
    assign bus.wb_sel_o = (state_q == RD) ? {SW{1'b1}} : wsel_q;
    assign bus.wb_bte_o = 2'b00;
    assign bus.wb_cti_o = (BURST_SUPPORT == 0 || state_q == IDLE) ? 3'b000
                        : (last ? 3'b111 : 3'b010);

    assign bus.s_av_waitrequest_o = ~ready_q
                                  | ~((state_q == IDLE) || (state_q == WR_GAP));
    assign bus.s_av_readdata_o      = rdata_q;
    assign bus.s_av_readdatavalid_o = rvalid_q;
    assign bus.err_o                = err_q;
endmodule

// File: doc/avalon_to_wb_bridge.md
Name: avalon_to_wb_bridge

Overview:
Avalon-MM slave to Wishbone B4 classic/registered-burst master. It lets an Avalon master (HPS lightweight/h2f bridge, debug JTAG master) reach the Zet Wishbone fabric (BIOS ROM, peripherals). It is the reverse of the existing Wishbone-to-Avalon SDRAM bridge.
Single clock domain; every Avalon burst becomes one Wishbone cycle (cyc held) with one stb/ack per beat.

Parameters:
DW, 32, data width in bits (multiple of 8)
AW, 30, word-address width on both sides
BCW, 8, Avalon burstcount width
BURST_SUPPORT, 1, 1 = drive cti/bte as incrementing burst; 0 = cti always 3'b000

Ports:
wb_clk_i  in  1  clock for both interfaces
wb_rst_i  in  1  reset, asynchronous, active-high
s_av_address_i  in  AW  Avalon word address
s_av_byteenable_i  in  DW/8  byte enables
s_av_read_i  in  1  read request
s_av_write_i  in  1  write request
s_av_writedata_i  in  DW  write data
s_av_burstcount_i  in  BCW  beats in burst (0 treated as 1)
s_av_readdata_o  out  DW  read data
s_av_readdatavalid_o  out  1  read data qualifier
s_av_waitrequest_o  out  1  stall
wb_adr_o  out  AW  Wishbone word address
wb_dat_o  out  DW  write data
wb_dat_i  in  DW  read data
wb_sel_o  out  DW/8  byte select
wb_we_o  out  1  write enable
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_cti_o  out  3  cycle type
wb_bte_o  out  2  burst type, constant 2'b00 (linear)
wb_ack_i  in  1  beat acknowledge
wb_err_i  in  1  beat error
err_o  out  1  sticky error flag

Behaviour:
- Reset (async, wb_rst_i=1): state IDLE, ready flop=0; waitrequest=1, readdatavalid=0, cyc=stb=we=0, adr/dat/sel=0, cti=000, readdata=0, err_o=0. Reset mid-burst aborts with no further readdatavalid; the Avalon master must reissue.
- ready flop goes to 1 on the first clock edge after reset release. waitrequest = ~ready | (state not in {IDLE, WR_GAP}).
- Internal regs: addr (AW), rem (BCW+1), wdat, wsel.
- IDLE: read has priority if read and write are both high. On read, latch address and burstcount (0->1), then go to RD. On write, latch address, data, byteenable and count, then go to WR. The command is accepted the same cycle (waitrequest=0).
- RD: cyc=stb=1, we=0, sel=all ones.
  - On ack: readdata<=wb_dat_i and readdatavalid=1 for exactly the next cycle. Then addr+1 and rem-1.
  - If rem==1, go to IDLE with cyc=stb=0 on the following cycle.
  - stb stays high across beats, so back-to-back acks give back-to-back valids.
- WR: cyc=stb=we=1, dat=wdat, sel=wsel.
  - On ack with rem==1, go to IDLE.
  - On ack with rem>1, go to WR_GAP: stb=0, cyc held, addr+1, rem-1.
- WR_GAP: waitrequest=0. Holds until s_av_write_i, then latches data and byteenable and goes to WR. s_av_read_i is ignored here.
- cti when BURST_SUPPORT=1: 3'b010 while rem>1, 3'b111 on the last beat, and 3'b111 for single beats. When BURST_SUPPORT=0: always 3'b000.
- wb_err_i terminates a beat exactly like ack and sets err_o (cleared only by reset). A read beat ending in err returns readdata all-ones.
- ack and err together count as one beat.
- Latency for a single read: command cycle, stb one cycle later, readdatavalid one cycle after ack. Minimum is 3 cycles with a zero-wait slave.
- Address wraps modulo 2^AW with no boundary check.
- Burst length max is 2^(BCW-1); larger values give undefined behaviour.

Test Plan:
- Reset release, then single read at addr 0x100 with the slave acking 0xA5A5_1234 in the 1st stb cycle -> wb_adr_o=0x100, cti=111, readdatavalid on cycle 3 with data 0xA5A5_1234, then cyc drops.
- Read burst of 4 from 0x3FFF_FFFE, slave acking every cycle with data=adr -> adr 3FFFFFFE, 3FFFFFFF, 0, 1 (wrap); cti 010,010,010,111; 4 consecutive valids.
- Write burst of 3 (data 11,22,33; be 0xF, 0x3, 0xC) with 2 wait states per ack and the master holding writes -> cyc continuous, stb low in gaps, sel F,3,C in order, waitrequest low only in IDLE and WR_GAP.
- Read and write asserted together in IDLE -> read serviced, we=0, write stalled by waitrequest until IDLE returns.
- wb_err_i on the 2nd beat of a 2-beat read -> valids with data then 0xFFFF_FFFF; err_o=1 and stays 1.
- wb_rst_i asserted mid-burst (beat 2 of 4) -> cyc/stb/readdatavalid 0 immediately; waitrequest 1 until 1 cycle after release; new read completes normally.
